// File: rtl/cva6_pma_pkg.sv
// Shared types, rule-table configuration and the range test used by the PMA lookup.
package cva6_pma_pkg;

  localparam int unsigned MaxRules = 16;

  typedef struct packed {
    logic cached;
    logic exec;
    logic nonidem;
    logic unmapped;
  } pma_attr_t;

  typedef struct packed {
    int unsigned                     NrNonIdempotentRules;
    logic [MaxRules-1:0][63:0]       NonIdempotentAddrBase;
    logic [MaxRules-1:0][63:0]       NonIdempotentLength;
    int unsigned                     NrExecuteRegionRules;
    logic [MaxRules-1:0][63:0]       ExecuteRegionAddrBase;
    logic [MaxRules-1:0][63:0]       ExecuteRegionLength;
    int unsigned                     NrCachedRegionRules;
    logic [MaxRules-1:0][63:0]       CachedRegionAddrBase;
    logic [MaxRules-1:0][63:0]       CachedRegionLength;
  } pma_cfg_t;

  // Default build: Debug, BootROM and DRAM executable, DRAM cached, no I/O windows.
  function automatic pma_cfg_t default_cfg();
    pma_cfg_t cfg;
    cfg = '0;
    cfg.NrNonIdempotentRules     = 2;
    cfg.NrExecuteRegionRules     = 3;
    cfg.ExecuteRegionAddrBase[0] = 64'h0000_0000;
    cfg.ExecuteRegionLength[0]   = 64'h0000_1000;
    cfg.ExecuteRegionAddrBase[1] = 64'h0001_0000;
    cfg.ExecuteRegionLength[1]   = 64'h0001_0000;
    cfg.ExecuteRegionAddrBase[2] = 64'h8000_0000;
    cfg.ExecuteRegionLength[2]   = 64'h4000_0000;
    cfg.NrCachedRegionRules      = 1;
    cfg.CachedRegionAddrBase[0]  = 64'h8000_0000;
    cfg.CachedRegionLength[0]    = 64'h4000_0000;
    return cfg;
  endfunction

  localparam pma_cfg_t DefaultCfg = default_cfg();

  // The end address is formed in 65 bits so a region touching 2^64 cannot wrap.
  function automatic logic range_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] len);
    logic [64:0] w_end;
    w_end = {1'b0, base} + {1'b0, len};
    return (len != 64'd0) && (addr >= base) && ({1'b0, addr} < w_end);
  endfunction

endpackage

// File: rtl/cva6_pma_range_match.sv
// Matches one address against a table of base/length rules; rules past NrRules never hit.
module cva6_pma_range_match
  import cva6_pma_pkg::*;
#(
  parameter int unsigned               NrRules  = 0,
  parameter logic [MaxRules-1:0][63:0] AddrBase = '0,
  parameter logic [MaxRules-1:0][63:0] Length   = '0
) (
  input  logic [63:0]         i_addr,
  output logic [MaxRules-1:0] o_hit,
  output logic                o_any
);

  genvar gi;
  generate
    for (gi = 0; gi < MaxRules; gi++) begin : g_rule
      if (gi < int'(NrRules)) begin : g_active
        assign o_hit[gi] = range_hit(i_addr, AddrBase[gi], Length[gi]);
      end else begin : g_unused
        assign o_hit[gi] = 1'b0;
      end
    end
  endgenerate

  assign o_any = |o_hit;

endmodule

// File: rtl/cva6_pma_lookup.sv
// Two-stage PMA attribute lookup with valid/ready handshake, full backpressure and flush.
module cva6_pma_lookup
  import cva6_pma_pkg::*;
#(
  parameter pma_cfg_t    CVA6Cfg   = DefaultCfg,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdWidth-1:0]   rsp_id_o,
  output logic                 rsp_cached_o,
  output logic                 rsp_exec_o,
  output logic                 rsp_nonidem_o,
  output logic                 rsp_unmapped_o
);

  logic                 r_s1_valid;
  logic [AddrWidth-1:0] r_s1_addr;
  logic [IdWidth-1:0]   r_s1_id;
  logic                 r_s2_valid;
  logic [IdWidth-1:0]   r_s2_id;
  pma_attr_t            r_s2_attr;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic [63:0]          w_addr64;
  logic [MaxRules-1:0]  w_cached_hit;
  logic [MaxRules-1:0]  w_exec_hit;
  logic [MaxRules-1:0]  w_nonidem_hit;
  logic                 w_cached_any;
  logic                 w_exec_any;
  logic                 w_nonidem_any;
  pma_attr_t            w_attr;

  // Ready depends only on pipeline state, rsp_ready_i and flush_i, never on req_valid_i.
  assign w_s2_adv    = !r_s2_valid || rsp_ready_i;
  assign w_s1_adv    = !r_s1_valid || w_s2_adv;
  assign req_ready_o = w_s1_adv && !flush_i;

  always_comb begin
    w_addr64                = '0;
    w_addr64[AddrWidth-1:0] = r_s1_addr;
  end

  cva6_pma_range_match #(
    .NrRules  (CVA6Cfg.NrCachedRegionRules),
    .AddrBase (CVA6Cfg.CachedRegionAddrBase),
    .Length   (CVA6Cfg.CachedRegionLength)
  ) u_cached (
    .i_addr (w_addr64),
    .o_hit  (w_cached_hit),
    .o_any  (w_cached_any)
  );

  cva6_pma_range_match #(
    .NrRules  (CVA6Cfg.NrExecuteRegionRules),
    .AddrBase (CVA6Cfg.ExecuteRegionAddrBase),
    .Length   (CVA6Cfg.ExecuteRegionLength)
  ) u_exec (
    .i_addr (w_addr64),
    .o_hit  (w_exec_hit),
    .o_any  (w_exec_any)
  );

  cva6_pma_range_match #(
    .NrRules  (CVA6Cfg.NrNonIdempotentRules),
    .AddrBase (CVA6Cfg.NonIdempotentAddrBase),
    .Length   (CVA6Cfg.NonIdempotentLength)
  ) u_nonidem (
    .i_addr (w_addr64),
    .o_hit  (w_nonidem_hit),
    .o_any  (w_nonidem_any)
  );

  always_comb begin
    w_attr          = '0;
    w_attr.cached   = w_cached_any;
    w_attr.exec     = w_exec_any;
    w_attr.nonidem  = w_nonidem_any;
    w_attr.unmapped = ~|(w_cached_hit | w_exec_hit | w_nonidem_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_id    <= '0;
    end else begin
      if (flush_i) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_adv) begin
        r_s1_valid <= req_valid_i;
      end
      if (req_valid_i && req_ready_o) begin
        r_s1_addr <= req_addr_i;
        r_s1_id   <= req_id_i;
      end
    end
  end

  // Data flops only load on a real transfer so held responses stay stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_attr  <= '0;
    end else begin
      if (flush_i) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_s2_id   <= r_s1_id;
        r_s2_attr <= w_attr;
      end
    end
  end

  assign rsp_valid_o    = r_s2_valid;
  assign rsp_id_o       = r_s2_id;
  assign rsp_cached_o   = r_s2_attr.cached;
  assign rsp_exec_o     = r_s2_attr.exec;
  assign rsp_nonidem_o  = r_s2_attr.nonidem;
  assign rsp_unmapped_o = r_s2_attr.unmapped;

endmodule

// File: tb/tb_cva6_pma_lookup.sv
// Directed bench for cva6_pma_lookup: address table plus backpressure, throughput, flush and reset sequences.
module tb_cva6_pma_lookup;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic [3:0]  req_id_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [3:0]  rsp_id_o;
  logic        rsp_cached_o;
  logic        rsp_exec_o;
  logic        rsp_nonidem_o;
  logic        rsp_unmapped_o;
  logic [3:0]  w_attr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  assign w_attr = {rsp_cached_o, rsp_exec_o, rsp_nonidem_o, rsp_unmapped_o};

  cva6_pma_lookup dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_id_i       (req_id_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_id_o       (rsp_id_o),
    .rsp_cached_o   (rsp_cached_o),
    .rsp_exec_o     (rsp_exec_o),
    .rsp_nonidem_o  (rsp_nonidem_o),
    .rsp_unmapped_o (rsp_unmapped_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // attr packs {cached, exec, nonidem, unmapped}
  typedef struct {
    logic [63:0] addr;
    logic [3:0]  id;
    logic [3:0]  attr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{64'h0000_0000_8000_0000, 4'h1, 4'b1100};
    vecs[1] = '{64'h0000_0000_BFFF_FFFF, 4'h1, 4'b1100};
    vecs[2] = '{64'h0000_0000_C000_0000, 4'h2, 4'b0001};
    vecs[3] = '{64'h0000_0000_0001_0000, 4'h3, 4'b0100};
    vecs[4] = '{64'h0000_0000_0001_FFFF, 4'h4, 4'b0100};
    vecs[5] = '{64'h0000_0000_0002_0000, 4'h5, 4'b0001};
    vecs[6] = '{64'h0000_0000_0000_0FFF, 4'h6, 4'b0100};
    vecs[7] = '{64'h0000_0000_0000_1000, 4'h7, 4'b0001};
    vecs[8] = '{64'h0000_0000_0000_0000, 4'h8, 4'b0100};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'h9, 4'b0001};

    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_id_i    = '0;
    rsp_ready_i = 1'b1;

    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id_o), 64'd0);
    chk("rst_rsp_attr", 64'(w_attr), 64'd0);
    rst_ni = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);

    // Single requests against the address table, two-cycle latency each.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b1;
      req_addr_i  = vecs[i].addr;
      req_id_i    = vecs[i].id;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      chk($sformatf("tbl%0d_lat1_valid", i), 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid_o), 64'd1);
      chk($sformatf("tbl%0d_id", i), 64'(rsp_id_o), 64'(vecs[i].id));
      chk($sformatf("tbl%0d_attr", i), 64'(w_attr), 64'(vecs[i].attr));
    end

    // Backpressure: two in flight, third refused, then drained in order.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h8000_0000;
    req_id_i    = 4'd1;
    chk("bp_ready1", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_id_i = 4'd2;
    chk("bp_ready2", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_id_i = 4'd3;
    chk("bp_ready3", 64'(req_ready_o), 64'd0);
    chk("bp_hold_valid_a", 64'(rsp_valid_o), 64'd1);
    chk("bp_hold_id_a", 64'(rsp_id_o), 64'd1);
    @(negedge clk_i);
    chk("bp_ready3_again", 64'(req_ready_o), 64'd0);
    chk("bp_hold_id_b", 64'(rsp_id_o), 64'd1);
    chk("bp_hold_attr_b", 64'(w_attr), 64'b1100);
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_ready_after_release", 64'(req_ready_o), 64'd1);
    chk("bp_out_id1", 64'(rsp_id_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("bp_out_valid2", 64'(rsp_valid_o), 64'd1);
    chk("bp_out_id2", 64'(rsp_id_o), 64'd2);
    @(negedge clk_i);
    chk("bp_out_valid3", 64'(rsp_valid_o), 64'd1);
    chk("bp_out_id3", 64'(rsp_id_o), 64'd3);
    @(negedge clk_i);
    chk("bp_drained", 64'(rsp_valid_o), 64'd0);

    // Throughput: eight back-to-back requests, eight consecutive responses.
    for (int c = 0; c < 11; c++) begin
      @(negedge clk_i);
      if (c >= 2 && c < 10) begin
        chk($sformatf("tp_c%0d_valid", c), 64'(rsp_valid_o), 64'd1);
        chk($sformatf("tp_c%0d_id", c), 64'(rsp_id_o), 64'(c - 2));
      end else begin
        chk($sformatf("tp_c%0d_valid", c), 64'(rsp_valid_o), 64'd0);
      end
      if (c < 8) begin
        chk($sformatf("tp_c%0d_ready", c), 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h8000_0000 + 64'(c * 8);
        req_id_i    = 4'(c);
      end else begin
        req_valid_i = 1'b0;
      end
    end

    // Flush: ids 4 and 5 in flight are dropped, request during flush refused.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h1_0000;
    req_id_i    = 4'd4;
    @(negedge clk_i);
    req_id_i = 4'd5;
    @(negedge clk_i);
    req_id_i = 4'd9;
    flush_i  = 1'b1;
    chk("fl_ready_in_flush", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("fl_quiet%0d", c), 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
    end
    req_valid_i = 1'b1;
    req_addr_i  = 64'h1_0000;
    req_id_i    = 4'd6;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("fl_id6_valid", 64'(rsp_valid_o), 64'd1);
    chk("fl_id6_id", 64'(rsp_id_o), 64'd6);
    chk("fl_id6_attr", 64'(w_attr), 64'b0100);

    // Asynchronous reset with two requests in flight.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h8000_0000;
    req_id_i    = 4'd10;
    @(negedge clk_i);
    req_id_i = 4'd11;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("rs_pre_valid", 64'(rsp_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rs_async_valid", 64'(rsp_valid_o), 64'd0);
    chk("rs_async_id", 64'(rsp_id_o), 64'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("rs_quiet%0d", c), 64'(rsp_valid_o), 64'd0);
      chk($sformatf("rs_ready%0d", c), 64'(req_ready_o), 64'd1);
    end
    req_valid_i = 1'b1;
    req_addr_i  = 64'hC000_0000;
    req_id_i    = 4'd12;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rs_new_valid", 64'(rsp_valid_o), 64'd1);
    chk("rs_new_id", 64'(rsp_id_o), 64'd12);
    chk("rs_new_attr", 64'(w_attr), 64'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
